// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

  // Sequencer phases: staged release, normal operation, soft-reset hold.
  typedef enum logic [1:0] {
    RELEASE     = 2'd0,
    RUN         = 2'd1,
    SOFT_ASSERT = 2'd2
  } rst_seq_state_t;

  // One counter serves both the release spacing and the soft hold, so it is
  // sized for the longer of the two, never narrower than one bit.
  function automatic int cnt_width(input int stage_dly, input int soft_hold);
    int span;
    span = (stage_dly > soft_hold) ? stage_dly : soft_hold;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  // Stage index width, never narrower than one bit.
  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases NUM_STAGES active-low resets in LSB-first
// order, STAGE_DLY clocks apart, and re-runs the sequence on a soft request
// after holding every stage asserted for SOFT_HOLD clocks.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_DLY  = 1024,
  parameter int SOFT_HOLD  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_rdy,
  output logic                  soft_rst_ack
);

  localparam int CNT_W = cnt_width(STAGE_DLY, SOFT_HOLD);
  localparam int IDX_W = idx_width(NUM_STAGES);

  localparam logic [CNT_W-1:0] REL_TC   = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(SOFT_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  rst_seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [NUM_STAGES-1:0] stage_nxt;
  logic                  all_rdy_nxt;
  logic                  ack_nxt;
  logic                  soft_pend, soft_pend_nxt;

  // State and registered outputs; rst_n forces every reset value at once.
  // NOTE: every flop here carries the async reset, so the outputs are
  // deterministic the instant rst_n falls, with no clock needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RELEASE;
      cnt          <= '0;
      idx          <= '0;
      stage_rst_n  <= '0;
      all_rdy      <= 1'b0;
      soft_rst_ack <= 1'b0;
      soft_pend    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values regardless of statement order.
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      stage_rst_n  <= stage_nxt;
      all_rdy      <= all_rdy_nxt;
      soft_rst_ack <= ack_nxt;
      soft_pend    <= soft_pend_nxt;
    end
  end

  // Next-state and next-output logic for the release / run / hold phases.
  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    stage_nxt     = stage_rst_n;
    all_rdy_nxt   = all_rdy;
    ack_nxt       = 1'b0;
    soft_pend_nxt = soft_pend;

    case (state)
      RELEASE: begin
        if (cnt == REL_TC) begin
          // Releasing stage idx keeps the outputs a thermometer code,
          // since idx only ever walks upward from 0.
          stage_nxt[idx] = 1'b1;
          cnt_nxt        = '0;
          idx_nxt        = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state_nxt     = RUN;
            idx_nxt       = '0;
            all_rdy_nxt   = 1'b1;
            ack_nxt       = soft_pend;
            soft_pend_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RUN: begin
        // Requests are honoured only here; elsewhere they are dropped.
        if (soft_rst_req) begin
          state_nxt     = SOFT_ASSERT;
          stage_nxt     = '0;
          all_rdy_nxt   = 1'b0;
          cnt_nxt       = '0;
          soft_pend_nxt = 1'b1;
        end
      end

      SOFT_ASSERT: begin
        if (cnt == HOLD_TC) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = RELEASE;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed timing tables for power-up and
// soft reset, hand-written corner sequences, and a randomized run against
// an elapsed-time reference model.
module tb_rst_seq;

  localparam int N = 3;
  localparam int D = 4;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         soft_rst_req;
  logic [N-1:0] stage_rst_n;
  logic         all_rdy;
  logic         soft_rst_ack;

  logic         rst_n_m;
  logic         req_m;
  logic [0:0]   stage_m;
  logic         rdy_m;
  logic         ack_m;

  always #5 clk = ~clk;

  rst_seq #(.NUM_STAGES(N), .STAGE_DLY(D), .SOFT_HOLD(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
    .stage_rst_n  (stage_rst_n),
    .all_rdy      (all_rdy),
    .soft_rst_ack (soft_rst_ack)
  );

  rst_seq #(.NUM_STAGES(1), .STAGE_DLY(1), .SOFT_HOLD(1)) dut_min (
    .clk          (clk),
    .rst_n        (rst_n_m),
    .soft_rst_req (req_m),
    .stage_rst_n  (stage_m),
    .all_rdy      (rdy_m),
    .soft_rst_ack (ack_m)
  );

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // Hold rst_n low across one edge, then release it; the next edge is edge 1.
  task automatic power_up();
    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e     = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Expected power-up outputs k edges after release, from the timing rules.
  function automatic logic [N-1:0] thermo(input int k);
    return N'((1 << k) - 1);
  endfunction

  function automatic logic [N-1:0] boot_stage(input int k);
    int rel;
    rel = k / D;
    if (rel > N) rel = N;
    return thermo(rel);
  endfunction

  // Reference model: tracks elapsed edges in each phase, not the RTL counters.
  typedef enum {M_RELEASING, M_RUNNING, M_HOLDING} m_mode_t;
  m_mode_t m_mode;
  int      m_t;
  int      m_h;
  logic    m_pend;
  logic    m_ack;

  task automatic model_reset();
    m_mode = M_RELEASING;
    m_t    = 0;
    m_h    = 0;
    m_pend = 1'b0;
    m_ack  = 1'b0;
  endtask

  task automatic model_edge(input logic req);
    m_ack = 1'b0;
    case (m_mode)
      M_RELEASING: begin
        m_t++;
        if (m_t == N * D) begin
          m_mode = M_RUNNING;
          m_ack  = m_pend;
          m_pend = 1'b0;
        end
      end
      M_RUNNING: begin
        if (req) begin
          m_mode = M_HOLDING;
          m_h    = 0;
          m_pend = 1'b1;
        end
      end
      default: begin
        m_h++;
        if (m_h == H) begin
          m_mode = M_RELEASING;
          m_t    = 0;
        end
      end
    endcase
  endtask

  function automatic logic [N-1:0] model_stage();
    if (m_mode == M_RELEASING) return thermo(m_t / D);
    if (m_mode == M_RUNNING) return '1;
    return '0;
  endfunction

  task automatic model_compare(input string tag);
    check({tag, " stage"}, 32'(stage_rst_n), 32'(model_stage()));
    check({tag, " all_rdy"}, 32'(all_rdy), 32'(m_mode == M_RUNNING));
    check({tag, " ack"}, 32'(soft_rst_ack), 32'(m_ack));
  endtask

  typedef struct {
    int           edge_n;
    logic [N-1:0] stg;
    logic         rdy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic req_s;
    logic rs;
    int   ti;

    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    rst_n_m      = 1'b0;
    req_m        = 1'b0;

    // Power-up (edges 1-19) then soft request sampled at edge 20.
    tbl.push_back('{1,  3'b000, 1'b0});
    tbl.push_back('{3,  3'b000, 1'b0});
    tbl.push_back('{4,  3'b001, 1'b0});
    tbl.push_back('{7,  3'b001, 1'b0});
    tbl.push_back('{8,  3'b011, 1'b0});
    tbl.push_back('{11, 3'b011, 1'b0});
    tbl.push_back('{12, 3'b111, 1'b1});
    tbl.push_back('{19, 3'b111, 1'b1});
    tbl.push_back('{20, 3'b000, 1'b0});
    tbl.push_back('{21, 3'b000, 1'b0});
    tbl.push_back('{25, 3'b000, 1'b0});
    tbl.push_back('{26, 3'b001, 1'b0});
    tbl.push_back('{29, 3'b001, 1'b0});
    tbl.push_back('{30, 3'b011, 1'b0});
    tbl.push_back('{33, 3'b011, 1'b0});
    tbl.push_back('{34, 3'b111, 1'b1});
    tbl.push_back('{36, 3'b111, 1'b1});

    // Reset state, observed while rst_n is still low.
    #2;
    check("reset stage", 32'(stage_rst_n), 32'h0);
    check("reset all_rdy", 32'(all_rdy), 32'h0);
    check("reset ack", 32'(soft_rst_ack), 32'h0);
    check("reset min stage", 32'(stage_m), 32'h0);

    // Scenarios 1 and 2: table-driven.
    power_up();
    ti = 0;
    for (int k = 1; k <= 36; k++) begin
      soft_rst_req = (k == 20);
      tick();
      check($sformatf("tbl e%0d ack", k), 32'(soft_rst_ack), 32'(k == 34));
      if (ti < tbl.size() && tbl[ti].edge_n == k) begin
        check($sformatf("tbl e%0d stage", k), 32'(stage_rst_n), 32'(tbl[ti].stg));
        check($sformatf("tbl e%0d all_rdy", k), 32'(all_rdy), 32'(tbl[ti].rdy));
        ti++;
      end
    end
    soft_rst_req = 1'b0;
    check("tbl entries visited", 32'(ti), 32'(tbl.size()));

    // Scenario 3: request during power-up is ignored and not queued.
    power_up();
    for (int k = 1; k <= 16; k++) begin
      soft_rst_req = (k >= 5 && k <= 7);
      tick();
      check($sformatf("s3 e%0d stage", k), 32'(stage_rst_n), 32'(boot_stage(k)));
      check($sformatf("s3 e%0d all_rdy", k), 32'(all_rdy), 32'(k >= 12));
      check($sformatf("s3 e%0d ack", k), 32'(soft_rst_ack), 32'h0);
    end
    soft_rst_req = 1'b0;

    // Scenario 4: async reset mid-release clears outputs without an edge.
    power_up();
    for (int k = 1; k <= 9; k++) tick();
    check("s4 pre stage", 32'(stage_rst_n), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    check("s4 async stage", 32'(stage_rst_n), 32'h0);
    check("s4 async all_rdy", 32'(all_rdy), 32'h0);
    power_up();
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("s4 e%0d stage", k), 32'(stage_rst_n), 32'(boot_stage(k)));
      check($sformatf("s4 e%0d all_rdy", k), 32'(all_rdy), 32'(k >= 12));
    end

    // Scenario 5: async reset during soft hold drops the pending ack.
    power_up();
    for (int k = 1; k <= 19; k++) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("s5 e20 stage", 32'(stage_rst_n), 32'h0);
    rst_n = 1'b0;
    tick();
    check("s5 e21 stage", 32'(stage_rst_n), 32'h0);
    check("s5 e21 all_rdy", 32'(all_rdy), 32'h0);
    rst_n = 1'b1;
    e     = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("s5 e%0d stage", k), 32'(stage_rst_n), 32'(boot_stage(k)));
      check($sformatf("s5 e%0d all_rdy", k), 32'(all_rdy), 32'(k >= 12));
      check($sformatf("s5 e%0d ack", k), 32'(soft_rst_ack), 32'h0);
    end

    // Scenario 6: minimum parameters on the second instance.
    rst_n_m = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      req_m = (k == 5);
      tick();
      check($sformatf("s6 e%0d stage", k), 32'(stage_m), 32'(!(k == 5 || k == 6)));
      check($sformatf("s6 e%0d all_rdy", k), 32'(rdy_m), 32'(!(k == 5 || k == 6)));
      check($sformatf("s6 e%0d ack", k), 32'(ack_m), 32'(k == 7));
    end
    req_m = 1'b0;

    // Randomized requests and async resets against the reference model.
    power_up();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5, 0) == 0) soft_rst_req = ~soft_rst_req;
      if (!rst_n) begin
        if ($urandom_range(1, 0) == 1) rst_n = 1'b1;
      end else if ($urandom_range(199, 0) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        model_compare("rnd async");
      end
      req_s = soft_rst_req;
      rs    = rst_n;
      tick();
      if (!rs) model_reset();
      else model_edge(req_s);
      model_compare("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
